// File: rtl/mult_mem_pkg.sv
// Shared types and default sizing for the multiplier product buffer arbiter.
package mult_mem_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mult_mem_arbiter_if.sv
// Requester-side handshakes plus the single-port memory bus of the arbiter.
interface mult_mem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_start;
  logic          rd_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  modport slave (
    input  wr_req, wr_data, rd_start, mem_rdata,
    output wr_gnt, rd_busy, rd_valid, rd_data, rd_last,
           mem_en, mem_we, mem_addr, mem_wdata, count, full, empty
  );

  modport master (
    output wr_req, wr_data, rd_start, mem_rdata,
    input  wr_gnt, rd_busy, rd_valid, rd_data, rd_last,
           mem_en, mem_we, mem_addr, mem_wdata, count, full, empty
  );
endinterface

// File: rtl/mult_mem_arbiter.sv
// Arbitrates one single-port memory between a product writer and a block reader;
// a block read returns every stored product in order and then empties the buffer.
module mult_mem_arbiter
  import mult_mem_pkg::*;
#(
  parameter int unsigned DEPTH = mult_mem_pkg::DEPTH,
  parameter int unsigned DW    = mult_mem_pkg::DW,
  parameter int unsigned AW    = mult_mem_pkg::AW
) (
  input logic               clk,
  input logic               rst,
  mult_mem_arbiter_if.slave bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;

  logic          full_int;
  logic          empty_int;
  logic          last_issue;
  logic          wr_gnt_c;
  logic          mem_en_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;

  assign full_int   = (count_q == DEPTH_C);
  assign empty_int  = (count_q == '0);
  assign last_issue = ({1'b0, rptr_q} == (len_q - CNT_ONE));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    rptr_d     = rptr_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_gnt_c   = 1'b0;
    mem_en_c   = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = count_q[AW-1:0];

    unique case (state_q)
      IDLE: begin
        // A pending block read wins the port over a write in the same cycle.
        if (bus.rd_start && !empty_int) begin
          state_d = READ;
          len_d   = count_q;
          rptr_d  = '0;
        end else if (bus.wr_req && !full_int) begin
          wr_gnt_c = 1'b1;
          mem_en_c = 1'b1;
          mem_we_c = 1'b1;
          count_d  = count_q + CNT_ONE;
        end
      end
      READ: begin
        mem_en_c   = 1'b1;
        mem_addr_c = rptr_q;
        rptr_d     = rptr_q + PTR_ONE;
        rd_valid_d = 1'b1;
        rd_last_d  = last_issue;
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      wr_gnt_c = 1'b0;
      mem_en_c = 1'b0;
      mem_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      len_q      <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Read data is passed straight through; rd_valid is aligned to the memory's one-cycle latency.
  assign bus.wr_gnt    = wr_gnt_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.rd_busy   = !rst && (state_q != IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.count     = count_q;
  assign bus.full      = !rst && full_int;
  assign bus.empty     = rst || empty_int;

endmodule

// File: tb/tb_mult_mem_arbiter.sv
// Self-checking bench for mult_mem_arbiter: queue-based buffer model plus a behavioural memory.
module tb_mult_mem_arbiter;

  localparam int unsigned DEPTH = mult_mem_pkg::DEPTH;
  localparam int unsigned DW    = mult_mem_pkg::DW;
  localparam int unsigned AW    = mult_mem_pkg::AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mult_mem_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rdata_r;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_r       <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_r;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0] model_q [$];

  // Observations of one block read
  logic [DW-1:0] rr_beats [$];
  int            rr_addrs [$];
  int  rr_busy, rr_last_idx, rr_nlast, rr_wr_in_busy, rr_first_v, rr_last_v;
  bit  rr_timeout, rr_start_gnt, rr_end_gnt, rr_end_valid;
  int  rr_end_addr;
  logic [DW-1:0] rr_end_wdata;

  task automatic step(input logic r, input logic wq, input logic [DW-1:0] wd, input logic rs);
    @(negedge clk);
    rst = r; bus.wr_req = wq; bus.wr_data = wd; bus.rd_start = rs;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    model_q.delete();
  endtask

  // Issues rd_start then records everything until the first non-busy cycle (left unadvanced).
  task automatic run_read(input logic hold_wr, input logic [DW-1:0] wd);
    bit done = 0;
    rr_beats.delete(); rr_addrs.delete();
    rr_busy = 0; rr_last_idx = -1; rr_nlast = 0; rr_wr_in_busy = 0;
    rr_first_v = -1; rr_last_v = -1; rr_timeout = 0;
    step(1'b0, hold_wr, wd, 1'b1);
    rr_start_gnt = bus.wr_gnt;
    for (int c = 0; c < int'(DEPTH) + 20; c++) begin
      step(1'b0, hold_wr, wd, 1'($urandom_range(0, 1)));
      if (bus.rd_last) rr_nlast++;
      if (bus.rd_valid && bus.rd_busy) begin
        rr_beats.push_back(bus.rd_data);
        if (rr_first_v < 0) rr_first_v = c;
        rr_last_v = c;
        if (bus.rd_last) rr_last_idx = rr_beats.size() - 1;
      end
      if (bus.rd_busy) begin
        rr_busy++;
        if (bus.mem_en && bus.mem_we) rr_wr_in_busy++;
        if (bus.wr_gnt) rr_wr_in_busy++;
        if (bus.mem_en && !bus.mem_we) rr_addrs.push_back(int'(bus.mem_addr));
      end else begin
        rr_end_gnt   = bus.wr_gnt;
        rr_end_addr  = int'(bus.mem_addr);
        rr_end_wdata = bus.mem_wdata;
        rr_end_valid = bus.rd_valid;
        done = 1;
        break;
      end
    end
    rr_timeout = !done;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, '1, 1'b1);
    step(1'b1, 1'b1, '1, 1'b1);
    n_run++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_wr_gnt got %b exp 0", bus.wr_gnt); end
    n_run++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); end
    n_run++; if (bus.rd_busy !== 1'b0) begin n_fail++; $display("FAIL rst_rd_busy got %b exp 0", bus.rd_busy); end
    n_run++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", bus.full); end
    n_run++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    step(1'b0, 1'b0, '0, 1'b0);
    n_run++; if (bus.count !== '0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_run++; if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b/%b exp 0/0", bus.rd_valid, bus.rd_last); end
    model_q.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 70; i++) begin
      bit exp_g = (model_q.size() < DEPTH);
      step(1'b0, 1'b1, DW'(i), 1'b0);
      n_run++; if (bus.count !== (AW+1)'(model_q.size())) begin n_fail++; $display("FAIL fill_count cyc %0d got %0d exp %0d", i, bus.count, model_q.size()); end
      n_run++; if (bus.wr_gnt !== exp_g) begin n_fail++; $display("FAIL fill_gnt cyc %0d got %b exp %b", i, bus.wr_gnt, exp_g); end
      if (exp_g) begin
        n_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || int'(bus.mem_addr) != model_q.size() || bus.mem_wdata !== DW'(i)) begin
          n_fail++; $display("FAIL fill_write cyc %0d got en=%b we=%b addr=%0d data=%0d exp 1/1/%0d/%0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, model_q.size(), i);
        end
        model_q.push_back(DW'(i));
      end else begin
        n_run++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL fill_nowrite cyc %0d mem_en got %b exp 0", i, bus.mem_en); end
      end
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_run++; if (bus.full !== 1'b1 || bus.count !== (AW+1)'(DEPTH)) begin n_fail++; $display("FAIL fill_full got full=%b count=%0d exp 1/%0d", bus.full, bus.count, DEPTH); end
  endtask

  task automatic test_full_readout();
    logic [DW-1:0] wd = DW'($urandom);
    run_read(1'b0, '0);
    n_run++; if (rr_timeout) begin n_fail++; $display("FAIL full_rd_timeout got busy beyond bound exp %0d cycles", DEPTH + 1); end
    n_run++; if (rr_busy != int'(DEPTH) + 1) begin n_fail++; $display("FAIL full_rd_busy got %0d exp %0d", rr_busy, DEPTH + 1); end
    n_run++; if (rr_beats.size() != DEPTH) begin n_fail++; $display("FAIL full_rd_nbeats got %0d exp %0d", rr_beats.size(), DEPTH); end
    for (int i = 0; i < rr_beats.size() && i < model_q.size(); i++) begin
      n_run++; if (rr_beats[i] !== model_q[i]) begin n_fail++; $display("FAIL full_rd_data beat %0d got %0h exp %0h", i, rr_beats[i], model_q[i]); end
    end
    n_run++; if (rr_last_idx != int'(DEPTH) - 1 || rr_nlast != 1) begin n_fail++; $display("FAIL full_rd_last got idx %0d n %0d exp %0d 1", rr_last_idx, rr_nlast, DEPTH - 1); end
    n_run++; if (rr_wr_in_busy != 0) begin n_fail++; $display("FAIL full_rd_wr_in_busy got %0d exp 0", rr_wr_in_busy); end
    model_q.delete();
    step(1'b0, 1'b1, wd, 1'b0);
    n_run++; if (bus.wr_gnt !== 1'b1 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL full_rd_next_write got gnt=%b addr=%0d exp 1/0", bus.wr_gnt, bus.mem_addr); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_partial_read();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, DW'(10 + i), 1'b0);
      n_run++; if (bus.wr_gnt !== 1'b1 || int'(bus.mem_addr) != i) begin n_fail++; $display("FAIL part_write %0d got gnt=%b addr=%0d exp 1/%0d", i, bus.wr_gnt, bus.mem_addr, i); end
      model_q.push_back(DW'(10 + i));
    end
    run_read(1'b0, '0);
    n_run++; if (rr_timeout || rr_busy != 6) begin n_fail++; $display("FAIL part_busy got %0d (timeout %0d) exp 6", rr_busy, rr_timeout); end
    n_run++; if (rr_addrs.size() != 5) begin n_fail++; $display("FAIL part_naddr got %0d exp 5", rr_addrs.size()); end
    for (int i = 0; i < rr_addrs.size() && i < 5; i++) begin
      n_run++; if (rr_addrs[i] != i) begin n_fail++; $display("FAIL part_addr %0d got %0d exp %0d", i, rr_addrs[i], i); end
    end
    n_run++; if (rr_beats.size() != 5 || rr_last_v - rr_first_v != 4) begin n_fail++; $display("FAIL part_beats got n=%0d span=%0d exp 5/4", rr_beats.size(), rr_last_v - rr_first_v); end
    for (int i = 0; i < rr_beats.size() && i < 5; i++) begin
      n_run++; if (rr_beats[i] !== DW'(10 + i)) begin n_fail++; $display("FAIL part_data beat %0d got %0d exp %0d", i, rr_beats[i], 10 + i); end
    end
    n_run++; if (rr_last_idx != 4 || rr_nlast != 1) begin n_fail++; $display("FAIL part_last got idx %0d n %0d exp 4 1", rr_last_idx, rr_nlast); end
    n_run++; if (bus.count !== '0 || bus.empty !== 1'b1 || rr_end_valid !== 1'b0) begin n_fail++; $display("FAIL part_after got count=%0d empty=%b valid=%b exp 0/1/0", bus.count, bus.empty, rr_end_valid); end
    model_q.delete();
  endtask

  task automatic test_collision();
    logic [DW-1:0] wd = DW'($urandom);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      step(1'b0, 1'b1, d, 1'b0);
      model_q.push_back(d);
    end
    run_read(1'b1, wd);
    n_run++; if (rr_start_gnt !== 1'b0) begin n_fail++; $display("FAIL coll_start_gnt got %b exp 0", rr_start_gnt); end
    n_run++; if (rr_timeout || rr_busy != 4 || rr_beats.size() != 3) begin n_fail++; $display("FAIL coll_len got busy=%0d beats=%0d exp 4/3", rr_busy, rr_beats.size()); end
    for (int i = 0; i < rr_beats.size() && i < 3; i++) begin
      n_run++; if (rr_beats[i] !== model_q[i]) begin n_fail++; $display("FAIL coll_data beat %0d got %0h exp %0h", i, rr_beats[i], model_q[i]); end
    end
    n_run++; if (rr_wr_in_busy != 0) begin n_fail++; $display("FAIL coll_wr_in_busy got %0d exp 0", rr_wr_in_busy); end
    n_run++; if (rr_end_gnt !== 1'b1 || rr_end_addr != 0 || rr_end_wdata !== wd) begin n_fail++; $display("FAIL coll_after_write got gnt=%b addr=%0d data=%0h exp 1/0/%0h", rr_end_gnt, rr_end_addr, rr_end_wdata, wd); end
    model_q.delete();
    model_q.push_back(wd);
    step(1'b0, 1'b0, '0, 1'b0);
    n_run++; if (bus.count !== (AW+1)'(1)) begin n_fail++; $display("FAIL coll_count got %0d exp 1", bus.count); end
  endtask

  task automatic test_empty_read();
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    n_run++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL empty_rd_mem_en got %b exp 0", bus.mem_en); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      n_run++; if (bus.rd_busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
        n_fail++; $display("FAIL empty_rd_idle cyc %0d got busy=%b valid=%b en=%b exp 0/0/0", i, bus.rd_busy, bus.rd_valid, bus.mem_en);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [DW-1:0] d = DW'($urandom);
      step(1'b0, 1'b1, d, 1'b0);
      model_q.push_back(d);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      n_run++; if (bus.rd_valid !== (k >= 2) || (k >= 2 && bus.rd_data !== model_q[k-2])) begin
        n_fail++; $display("FAIL midrst_beat cyc %0d got valid=%b data=%0h exp %b/%0h", k, bus.rd_valid, bus.rd_data, k >= 2, (k >= 2) ? model_q[k-2] : '0);
      end
    end
    step(1'b1, 1'b1, '0, 1'b0);
    n_run++; if (bus.wr_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.rd_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_during got gnt=%b en=%b busy=%b exp 0/0/0", bus.wr_gnt, bus.mem_en, bus.rd_busy); end
    model_q.delete();
    step(1'b0, 1'b0, '0, 1'b0);
    n_run++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.rd_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_after got count=%0d empty=%b busy=%b exp 0/1/0", bus.count, bus.empty, bus.rd_busy); end
    for (int i = 0; i < 5; i++) begin
      n_run++; if (bus.rd_valid !== 1'b0 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet cyc %0d got valid=%b en=%b exp 0/0", i, bus.rd_valid, bus.mem_en); end
      step(1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int ncyc = $urandom_range(1, 90);
      for (int c = 0; c < ncyc; c++) begin
        logic          wq = ($urandom_range(0, 2) != 0);
        logic [DW-1:0] wd = DW'($urandom);
        bit            exp_g = wq && (model_q.size() < DEPTH);
        step(1'b0, wq, wd, 1'b0);
        n_run++; if (bus.wr_gnt !== exp_g || (exp_g && int'(bus.mem_addr) != model_q.size())) begin
          n_fail++; $display("FAIL rand_write r%0d c%0d got gnt=%b addr=%0d exp %b/%0d", r, c, bus.wr_gnt, bus.mem_addr, exp_g, model_q.size());
        end
        if (exp_g) model_q.push_back(wd);
      end
      if (model_q.size() == 0) continue;
      run_read(1'b0, '0);
      n_run++; if (rr_timeout || rr_busy != model_q.size() + 1 || rr_beats.size() != model_q.size()) begin
        n_fail++; $display("FAIL rand_read r%0d got busy=%0d beats=%0d exp %0d/%0d", r, rr_busy, rr_beats.size(), model_q.size() + 1, model_q.size());
      end
      for (int i = 0; i < rr_beats.size() && i < model_q.size(); i++) begin
        n_run++; if (rr_beats[i] !== model_q[i]) begin n_fail++; $display("FAIL rand_data r%0d beat %0d got %0h exp %0h", r, i, rr_beats[i], model_q[i]); end
      end
      n_run++; if (rr_last_idx != model_q.size() - 1 || rr_nlast != 1) begin n_fail++; $display("FAIL rand_last r%0d got idx %0d n %0d exp %0d 1", r, rr_last_idx, rr_nlast, model_q.size() - 1); end
      model_q.delete();
    end
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_data = '0; bus.rd_start = 1'b0;
    test_reset();
    test_fill();
    test_full_readout();
    test_partial_read();
    test_collision();
    test_empty_read();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_mem_arbiter.md
MULT_MEM_ARBITER -- requirements
Module: mult_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64: product buffer entries.
REQ-002 Parameter DW, default 32: product data width.
REQ-003 Parameter AW, default 6: memory address width (log2 DEPTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 wr_req  in  1  multiplier has a product to store.
REQ-007 wr_data  in  DW  product value.
REQ-008 wr_gnt  out  1  product accepted and written this cycle.
REQ-009 rd_start  in  1  request block read of all stored products.
REQ-010 rd_busy  out  1  block read in progress.
REQ-011 rd_valid  out  1  rd_data holds a valid entry.
REQ-012 rd_data  out  DW  entry read from memory.
REQ-013 rd_last  out  1  rd_valid beat is the final entry.
REQ-014 mem_en / mem_we  out  1 each  single-port memory enable / write enable.
REQ-015 mem_addr  out  AW;  mem_wdata  out  DW;  mem_rdata  in  DW (read data 1 cycle after mem_en with mem_we=0).
REQ-016 count  out  AW+1  stored entries, 0..DEPTH;  full  out  1  (count==DEPTH);  empty  out  1  (count==0).

Function
REQ-017 FSM states IDLE, READ, DRAIN; the memory port SHALL be owned by exactly one requester per cycle.
REQ-018 wr_gnt SHALL be combinational: wr_req AND state==IDLE AND NOT full AND NOT (rd_start AND NOT empty).
REQ-019 When wr_gnt=1: mem_en=1, mem_we=1, mem_addr=wptr, mem_wdata=wr_data in the same cycle; wptr and count increment at the next edge.
REQ-020 wptr SHALL equal count[AW-1:0]; entries fill addresses 0..DEPTH-1 in order, with no wrap while full.
REQ-021 wr_req while full or while not in IDLE: wr_gnt=0, no memory write, no state change; requester holds data.
REQ-022 IDLE with rd_start=1 and count>0: latch len=count, rptr=0, go to READ; rd_start has priority over a simultaneous wr_req.
REQ-023 rd_start while empty, or while in READ/DRAIN, SHALL be ignored.
REQ-024 READ: mem_en=1, mem_we=0, mem_addr=rptr each cycle; rptr increments; after issuing address len-1, go to DRAIN.
REQ-025 rd_valid SHALL assert exactly one cycle after each read issue, with rd_data=mem_rdata; len consecutive beats, no gaps.
REQ-026 rd_last=1 only with the beat for address len-1 (in DRAIN).
REQ-027 DRAIN: no memory access; at the edge ending DRAIN, count=0 and wptr=0, state=IDLE (buffer consumed).
REQ-028 rd_busy=1 in READ and DRAIN; total busy = len+1 cycles.
REQ-029 mem_en=0 in every cycle not covered by REQ-019 or REQ-024.

Reset
REQ-030 rst=1 at an edge SHALL force state=IDLE, count=0, wptr=0, rptr=0, len=0, rd_valid=0, rd_last=0, regardless of state.
REQ-031 Reset mid-READ SHALL abort the block read: no further rd_valid beats, and stored data is discarded (count=0).
REQ-032 While rst=1: wr_gnt=0, mem_en=0, rd_busy=0, full=0, empty=1.

Structure
REQ-033 A shared package mult_mem_pkg SHALL hold the state enum type and constants DEPTH, AW and DW; the module imports it.
REQ-034 The block SHALL be flat, with no sub-module; the memory macro is external to it.

Verification
REQ-035 Fill: wr_req=1 for 70 cycles with wr_data=i -> 64 grants at addresses 0..63, full=1 after the 64th, then wr_gnt=0 for the remaining 6 cycles.
REQ-036 Partial read: 5 writes (values 10..14), then rd_start -> reads of addresses 0..4, rd_valid beats 10..14 on 5 consecutive cycles, rd_last on 14, rd_busy for 6 cycles, then count=0.
REQ-037 Collision: count=3, wr_req and rd_start both high in IDLE -> wr_gnt=0, READ entered, len=3; write granted the first IDLE cycle after DRAIN, at address 0.
REQ-038 Empty read: rd_start with count=0 -> stays IDLE, no mem_en, no rd_valid.
REQ-039 Reset mid-read: full buffer, rd_start, rst=1 on the 10th READ cycle -> next cycle IDLE, count=0, no further rd_valid.
REQ-040 Full read-out: 64 entries, rd_start -> 64 beats, rd_last on address 63, rd_busy for 65 cycles; a write immediately after lands at address 0.
